pool_binarize: RTL

POOL_BINARIZE -- requirements
Module: pool_binarize

---
 rtl/pool_binarize.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/pool_binarize.sv
// pool_binarize
//   Thresholds a raster stream of signed pooled samples and packs the
//   resulting bits into rows. Column c of a row lands in dout[c]; each
//   completed row is presented for one cycle on ovalid.
//   Frame geometry is chosen per frame by 'state': 0 -> 12x12, 1 -> 4x4.
//   The mode (and threshold, when enabled) is captured on the first sample
//   of a frame and held until the frame's last sample is accepted.
//
//   Optional feature macro: POOL_BINARIZE_THRESH_EN
//     defined   : adds input 'thr', a per-frame signed threshold
//     undefined : threshold is the constant 0
//
// Ports
//   clk      in   clock, rising edge
//   rstn     in   asynchronous active-low reset
//   ivalid   in   din holds a sample this cycle
//   state    in   layer mode for the next frame (0 = 12x12, 1 = 4x4)
//   din      in   signed sample, raster order
//   thr      in   signed threshold (only with POOL_BINARIZE_THRESH_EN)
//   ovalid   out  one-cycle pulse, dout/row_idx/olast valid
//   dout     out  packed binary row, bits above the row width are 0
//   row_idx  out  row number of dout
//   olast    out  final row of the frame (only with ovalid)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | between frames; next accepted sample starts a frame and
//       | captures mode/threshold
// RUN   | inside a frame; counters advance on each accepted sample
module pool_binarize #(
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     ivalid,
  input  logic                     state,
  input  logic signed [DATA_W-1:0] din,
`ifdef POOL_BINARIZE_THRESH_EN
  input  logic signed [DATA_W-1:0] thr,
`endif
  output logic                     ovalid,
  output logic [11:0]              dout,
  output logic [3:0]               row_idx,
  output logic                     olast
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fsm_t;

  fsm_t fsm_q, fsm_d;

  logic        mode_q;
  logic [3:0]  col_q;
  logic [3:0]  row_q;
  logic [11:0] row_buf_q;
`ifdef POOL_BINARIZE_THRESH_EN
  logic signed [DATA_W-1:0] thr_q;
`endif

  logic                     cfg_load;
  logic                     mode_cur;
  logic signed [DATA_W-1:0] thr_cur;
  logic [3:0]               last_col;
  logic [3:0]               last_row;
  logic                     smp_bit;
  logic [11:0]              row_next;
  logic                     row_done;
  logic                     frame_done;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) fsm_q <= IDLE;
    else       fsm_q <= fsm_d;
  end

  // Next-state logic
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE: if (ivalid)     fsm_d = RUN;
      RUN:  if (frame_done) fsm_d = IDLE;
      default:              fsm_d = IDLE;
    endcase
  end

  // Output / control decode. On the frame's first sample the live inputs
  // are used directly, since the latched copies are only written that edge.
  always_comb begin
    cfg_load = (fsm_q == IDLE) && ivalid;
    mode_cur = (fsm_q == IDLE) ? state : mode_q;
`ifdef POOL_BINARIZE_THRESH_EN
    thr_cur  = (fsm_q == IDLE) ? thr : thr_q;
`else
    thr_cur  = '0;
`endif
    last_col = mode_cur ? 4'd3 : 4'd11;
    last_row = mode_cur ? 4'd3 : 4'd11;
    smp_bit  = (din >= thr_cur);
    row_next = row_buf_q;
    row_next[col_q] = smp_bit;
    row_done   = ivalid && (col_q == last_col);
    frame_done = row_done && (row_q == last_row);
  end

  // Datapath: counters, row assembly, registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_q    <= 1'b0;
      col_q     <= 4'd0;
      row_q     <= 4'd0;
      row_buf_q <= 12'd0;
      ovalid    <= 1'b0;
      olast     <= 1'b0;
      dout      <= 12'd0;
      row_idx   <= 4'd0;
`ifdef POOL_BINARIZE_THRESH_EN
      thr_q     <= '0;
`endif
    end else begin
      ovalid <= 1'b0;
      olast  <= 1'b0;
      if (cfg_load) begin
        mode_q <= state;
`ifdef POOL_BINARIZE_THRESH_EN
        thr_q  <= thr;
`endif
      end
      if (ivalid) begin
        if (row_done) begin
          dout      <= row_next;
          row_idx   <= row_q;
          ovalid    <= 1'b1;
          olast     <= (row_q == last_row);
          // Cleared so bits from this row cannot leak into the next one
          row_buf_q <= 12'd0;
          col_q     <= 4'd0;
          row_q     <= (row_q == last_row) ? 4'd0 : row_q + 4'd1;
        end else begin
          row_buf_q <= row_next;
          col_q     <= col_q + 4'd1;
        end
      end
    end
  end

endmodule
